// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram: one-clock block RAM; one write port, one registered read port, read-first, storage has no reset
// Ports: clock; read_enable, read_addr, read_data (registered); write_enable, write_addr, write_data
module simple_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clock) begin
        if (write_enable) mem[write_addr] <= write_data;
        if (read_enable) read_data <= mem[read_addr];
    end
endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO on a simple dual-port RAM; occupancy count, full/empty/almost flags, sticky overflow/underflow
// Ports: clock, reset (sync, high), clock_enable; write_enable/write_data push; read_enable pop -> read_data/read_valid after one edge;
//        empty, full, almost_empty, almost_full, fill_count decoded from the registered count; overflow/underflow sticky errors
module fifo_buffer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int ALMOST_MARGIN = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clock_enable,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    logic [ADDR_WIDTH-1:0] write_ptr, read_ptr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  pop, push, no_pop_yet;
    assign pop  = clock_enable && read_enable && !empty;
    assign push = clock_enable && write_enable && (!full || pop);
    assign empty        = fill_count == '0;
    assign full         = fill_count == (ADDR_WIDTH+1)'(DEPTH);
    assign almost_empty = fill_count <= (ADDR_WIDTH+1)'(ALMOST_MARGIN);
    assign almost_full  = fill_count >= (ADDR_WIDTH+1)'(DEPTH - ALMOST_MARGIN);
    // The RAM output register has no reset, so read_data reads as zero until the first pop after reset.
    assign read_data = no_pop_yet ? '0 : ram_data;
    simple_dual_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) ram (
        .clock       (clock),
        .read_enable (pop && !reset),
        .read_addr   (read_ptr),
        .read_data   (ram_data),
        .write_enable(push && !reset),
        .write_addr  (write_ptr),
        .write_data  (write_data)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            write_ptr  <= '0;
            read_ptr   <= '0;
            fill_count <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            no_pop_yet <= 1'b1;
        end else if (clock_enable) begin
            write_ptr  <= write_ptr + ADDR_WIDTH'(push);
            read_ptr   <= read_ptr + ADDR_WIDTH'(pop);
            fill_count <= fill_count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
            read_valid <= pop;
            if (write_enable && !push) overflow <= 1'b1;
            if (read_enable && !pop) underflow <= 1'b1;
            if (pop) no_pop_yet <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed and random stimulus for fifo_buffer (8x4, margin 1) checked against a queue model
module tb_fifo_buffer;
    logic       clock = 1'b0, reset = 1'b0, clock_enable = 1'b0;
    logic       write_enable = 1'b0, read_enable = 1'b0;
    logic [7:0] write_data = '0, read_data;
    logic       read_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [2:0] fill_count;
    int         checks = 0, errors = 0;
    logic [7:0] q[$];
    logic [7:0] m_data = '0;
    logic       m_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    fifo_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ALMOST_MARGIN(1)) dut (
        .clock(clock), .reset(reset), .clock_enable(clock_enable),
        .write_enable(write_enable), .write_data(write_data), .read_enable(read_enable),
        .read_data(read_data), .read_valid(read_valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .fill_count(fill_count),
        .overflow(overflow), .underflow(underflow)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input logic ce, input logic rs, input logic we, input logic [7:0] wd, input logic re);
        logic pop_ok, push_ok;
        @(negedge clock);
        clock_enable = ce; reset = rs; write_enable = we; write_data = wd; read_enable = re;
        @(posedge clock);
        if (rs) begin
            q.delete(); m_data = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        end else if (ce) begin
            pop_ok  = re && q.size() > 0;
            push_ok = we && (q.size() < 4 || pop_ok);
            if (pop_ok) m_data = q.pop_front();
            if (push_ok) q.push_back(wd);
            m_valid = pop_ok;
            if (we && !push_ok) m_ovf = 1;
            if (re && !pop_ok) m_unf = 1;
        end
        #1;
        check("read_data", read_data, m_data);
        check("read_valid", read_valid, m_valid);
        check("fill_count", fill_count, q.size());
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == 4);
        check("almost_empty", almost_empty, q.size() <= 1);
        check("almost_full", almost_full, q.size() >= 3);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_unf);
    endtask
    initial begin
        cyc(1, 1, 0, 8'h00, 0);
        cyc(0, 1, 1, 8'h77, 1);
        cyc(1, 0, 1, 8'hA5, 0);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 0);
        for (int i = 1; i <= 5; i++) cyc(1, 0, 1, (i == 5) ? 8'hFF : 8'(i), 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 1, 8'h33, 1);
        cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 1, 0, 8'h00, 0);
        for (int i = 1; i <= 4; i++) cyc(1, 0, 1, 8'(i), 0);
        cyc(1, 0, 1, 8'h55, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'h00, 1);
        cyc(1, 0, 1, 8'h10, 0);
        for (int i = 1; i <= 9; i++) cyc(1, 0, 1, 8'(8'h10 + i), 1);
        cyc(1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 8'(8'h60 + i), 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'hEE, 1);
        cyc(1, 0, 1, 8'hFF, 1);
        cyc(1, 0, 1, 8'hFF, 1);
        cyc(1, 0, 1, 8'h00, 1);
        cyc(1, 0, 1, 8'h01, 0);
        cyc(1, 0, 1, 8'h02, 0);
        cyc(1, 1, 1, 8'h99, 0);
        cyc(1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 600; i++) begin
            int bias = (i / 50) % 3;
            cyc($urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0,
                $urandom_range(0, 3) < (bias == 0 ? 3 : bias == 1 ? 1 : 2), 8'($urandom),
                $urandom_range(0, 3) < (bias == 0 ? 1 : bias == 1 ? 3 : 2));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
